// File: rtl/apb_reg_slave.sv
// APB slave with a bank of 32-bit read/write registers, programmable wait states
// and pslverr on misaligned or out-of-range addresses.
module apb_reg_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              take_setup;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a < ADDR_W'(4 * NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  // A setup phase seen in DONE is a back-to-back transfer and is treated as from IDLE.
  always_comb take_setup = psel && !penable && (state != WAIT);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (take_setup) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
      cnt     <= 4'(WAIT_STATES);
      state   <= WAIT;
      // Zero-wait transfers must complete in A1, so the response is built from the live bus.
      if (WAIT_STATES == 0) begin
        pready  <= 1'b1;
        pslverr <= !addr_ok(paddr);
        prdata  <= (!pwrite && addr_ok(paddr)) ? regs[addr_idx(paddr)] : '0;
      end else begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
        prdata  <= '0;
      end
    end else begin
      case (state)
        WAIT: begin
          if (!psel) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
          end else if (penable) begin
            if (pready) begin
              if (write_q && addr_ok(addr_q)) regs[addr_idx(addr_q)] <= wdata_q;
              state   <= DONE;
              pready  <= 1'b0;
              pslverr <= 1'b0;
              prdata  <= '0;
            end else begin
              cnt <= cnt - 4'd1;
              if (cnt == 4'd1) begin
                pready  <= 1'b1;
                pslverr <= !addr_ok(addr_q);
                prdata  <= (!write_q && addr_ok(addr_q)) ? regs[addr_idx(addr_q)] : '0;
              end
            end
          end
        end
        DONE: begin
          if (!penable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
